// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the RV32I MEM stage and a word-addressed
// data RAM. It handles one request at a time. It checks funct3 and alignment,
// then drives a lane-enabled word access and waits for mem_ready. Load data is
// returned sign- or zero-extended with a one-cycle done pulse. Rejected or
// timed-out accesses end with cpu_err and never touch memory contents.
module lsu_ctrl #(
    parameter int TIMEOUT = 15              // max REQ cycles without mem_ready, 1..255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic        req_reject;
    logic        timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_shifted;
    logic [31:0] load_fmt;

    // Classify the incoming request: illegal funct3 or misaligned address.
    always_comb begin
        if (cpu_we)
            req_illegal = cpu_funct3[2] || (cpu_funct3[1:0] == 2'b11);
        else
            req_illegal = (cpu_funct3 == 3'b011) || (cpu_funct3[2:1] == 2'b11);
        req_misaligned = ((cpu_funct3[1:0] == 2'b01) && cpu_addr[0]) ||
                         ((cpu_funct3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));
        req_reject     = req_illegal || req_misaligned;
    end

    // The wait counter reaching its last allowed value with no ready ends REQ.
    assign timeout_hit = (cnt_q == CNT_LAST) && !mem_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (cpu_req) state_d = req_reject ? S_RESP : S_REQ;
            S_REQ:  if (mem_ready || timeout_hit) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latch request fields on acceptance; track error status and the wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= 8'h0;
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        f3_q    <= cpu_funct3;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        err_q   <= req_reject;
                    end
                end
                S_REQ: begin
                    if (mem_ready)        err_q <= 1'b0;
                    else if (timeout_hit) err_q <= 1'b1;
                    else                  cnt_q <= cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Byte lanes and replicated write data for the latched access size and offset.
    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = 32'h0;
        case (f3_q[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    // Align the RAM word to the addressed byte and extend to 32 bits.
    always_comb begin
        load_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_fmt = {{24{load_shifted[7]}},  load_shifted[7:0]};
            3'b001:  load_fmt = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_fmt = {24'h0, load_shifted[7:0]};
            3'b101:  load_fmt = {16'h0, load_shifted[15:0]};
            default: load_fmt = load_shifted;
        endcase
    end

    // Load result register: updated on a successful load, cleared on an erroring load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'h0;
        end else if (state_q == S_IDLE) begin
            if (cpu_req && req_reject && !cpu_we) rdata_q <= 32'h0;
        end else if (state_q == S_REQ && !we_q) begin
            if (mem_ready)        rdata_q <= load_fmt;
            else if (timeout_hit) rdata_q <= 32'h0;
        end
    end

    // Outputs decoded from state; RAM-side fields are zero outside REQ.
    always_comb begin
        cpu_busy  = (state_q != S_IDLE);
        cpu_done  = (state_q == S_RESP);
        cpu_err   = (state_q == S_RESP) && err_q;
        cpu_rdata = rdata_q;
        mem_req   = (state_q == S_REQ);
        mem_we    = mem_req && we_q;
        mem_be    = mem_req ? lane_be : 4'b0000;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wdata = mem_we ? lane_wdata : 32'h0;
    end

endmodule
